nibble_deserializer: RTL and testbench

Serial-to-parallel reader. Collects single bits from a bit-stream producer into WIDTH-bit words and presents each word on a valid/ready output port. Word assembly and the meaning of every bit are 4-state-aware: X/Z input bits are stored unchanged and flagged per word. Sits between a 1-bit serial source and any nibble-wide consumer, and is the receive end of the word-to-bit extraction path.

---
 rtl/nibble_deser_pkg.sv | 13 +
 rtl/sat_counter.sv | 34 +++
 rtl/nibble_deserializer.sv | 105 ++++++++++
 tb/tb_nibble_deserializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_deser_pkg.sv
// Shared defaults and 4-state helpers
// for the nibble deserializer.
package nibble_deser_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Neither 0 nor 1 under case equality.
  function automatic logic is_xz(input logic b);
    return (b !== 1'b0) && (b !== 1'b1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step unless already full.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel reader: packs bits
// into WIDTH-bit words, flags X/Z words.
module nibble_deserializer
  import nibble_deser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             out_ready,
  output logic             data_xz,
  output logic [CNT_W-1:0] xz_words
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             dxz_q, dxz_d;

  logic             accept;
  logic             xfer;
  logic             bit_xz;
  logic [WIDTH-1:0] shifted;

  assign bit_ready = !(valid_q && !out_ready);
  assign accept    = (bit_valid === 1'b1) && bit_ready;
  assign xfer      = valid_q && out_ready;
  assign bit_xz    = is_xz(bit_in);
  assign shifted   = (LSB_FIRST != 0)
                   ? {bit_in, sr_q[WIDTH-1:1]}
                   : {sr_q[WIDTH-2:0], bit_in};

  // Shift in accepted bits; load the word
  // on the last one, drop it on transfer.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    dxz_d   = dxz_q;
    if (xfer) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (cnt_q == LAST) begin
        data_d  = shifted;
        valid_d = 1'b1;
        dxz_d   = acc_q | bit_xz;
        sr_d    = '0;
        cnt_d   = '0;
        acc_d   = 1'b0;
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_q + CW'(1);
        acc_d = acc_q | bit_xz;
      end
    end
  end

  // Word assembly and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      dxz_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      dxz_q   <= dxz_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_xz_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (xfer && dxz_q),
    .count(xz_words)
  );

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign data_xz    = dxz_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Directed bench for nibble_deserializer:
// LSB-first default and MSB-first CNT_W=2.
module tb_nibble_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic       bit_ready_a;
  logic [3:0] data_out_a;
  logic       data_valid_a;
  logic       data_xz_a;
  logic [7:0] xz_words_a;

  logic       bit_ready_b;
  logic [3:0] data_out_b;
  logic       data_valid_b;
  logic       data_xz_b;
  logic [1:0] xz_words_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_deserializer #(
    .WIDTH(4), .LSB_FIRST(1), .CNT_W(8)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready_a),
    .data_out  (data_out_a),
    .data_valid(data_valid_a),
    .out_ready (out_ready),
    .data_xz   (data_xz_a),
    .xz_words  (xz_words_a)
  );

  nibble_deserializer #(
    .WIDTH(4), .LSB_FIRST(0), .CNT_W(2)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready_b),
    .data_out  (data_out_b),
    .data_valid(data_valid_b),
    .out_ready (out_ready),
    .data_xz   (data_xz_b),
    .xz_words  (xz_words_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic send(input logic b);
    @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [3:0] b);
    for (int i = 0; i < 4; i++) send(b[i]);
  endtask

  logic xb;
  logic zb;
  logic xb_xz;
  logic zb_xz;
  logic [3:0] w4;
  logic [3:0] exp4;
  int exp_a;
  int exp_b;

  initial begin
    xb    = 1'bx;
    zb    = 1'bz;
    xb_xz = (xb !== 1'b0) && (xb !== 1'b1);
    zb_xz = (zb !== 1'b0) && (zb !== 1'b1);

    // 1: reset, then 1,1,0,1 -> 4'hB
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", data_out_a, 0);
    chk("rst_valid", data_valid_a, 0);
    chk("rst_xz", data_xz_a, 0);
    chk("rst_cnt", xz_words_a, 0);
    chk("rst_ready", bit_ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1);
    send(1'b1);
    send(1'b0);
    chk("t1_pre_valid", data_valid_a, 0);
    send(1'b1);
    chk("t1_valid", data_valid_a, 1);
    chk("t1_data", data_out_a, 4'hB);
    chk("t1_xz", data_xz_a, 0);
    idle();
    chk("t1_one_cycle", data_valid_a, 0);

    // 2: 1,x,0,1 -> 4'b10x1 with xz flag
    send(1'b1);
    send(xb);
    send(1'b0);
    send(1'b1);
    w4 = {1'b1, 1'b0, xb, 1'b1};
    chk("t2_data", data_out_a, w4);
    chk("t2_xz", data_xz_a, xb_xz);
    chk("t2_cnt_pre", xz_words_a, 0);
    idle();
    chk("t2_cnt_post", xz_words_a, 32'(xb_xz));
    exp_a = int'(xb_xz);

    // 3: backpressure on word 1,0,1,0
    @(negedge clk);
    out_ready = 1'b0;
    send4(4'b0101);
    chk("t3_valid", data_valid_a, 1);
    chk("t3_data", data_out_a, 4'h5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      #1;
      chk("t3_bp_ready", bit_ready_a, 0);
      @(posedge clk);
      #1;
      chk("t3_bp_hold", data_out_a, 4'h5);
      chk("t3_bp_valid", data_valid_a, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    bit_valid = 1'b0;
    #1;
    chk("t3_ready_up", bit_ready_a, 1);
    @(posedge clk);
    #1;
    chk("t3_drained", data_valid_a, 0);
    send(1'b0);
    send(1'b0);
    send(1'b0);
    send(1'b1);
    chk("t3_word2", data_out_a, 4'h8);
    chk("t3_word2_v", data_valid_a, 1);

    // 4: back-to-back 5, A, F
    send4(4'b0101);
    chk("t4_w0", data_out_a, 4'h5);
    chk("t4_w0_v", data_valid_a, 1);
    chk("t4_w0_rdy", bit_ready_a, 1);
    send4(4'b1010);
    chk("t4_w1", data_out_a, 4'hA);
    chk("t4_w1_v", data_valid_a, 1);
    chk("t4_w1_rdy", bit_ready_a, 1);
    send4(4'b1111);
    chk("t4_w2", data_out_a, 4'hF);
    chk("t4_w2_v", data_valid_a, 1);
    idle();
    chk("t4_end_v", data_valid_a, 0);

    // 5: reset mid-word, then 1,0,0,0
    send(1'b1);
    send(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_a", data_out_a, 0);
    chk("t5_rst_b", data_out_b, 0);
    chk("t5_rst_bv", data_valid_b, 0);
    chk("t5_rst_bc", xz_words_b, 0);
    chk("t5_rst_ac", xz_words_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1);
    send(1'b0);
    send(1'b0);
    chk("t5_no_stale", data_valid_b, 0);
    send(1'b0);
    chk("t5_msb_first", data_out_b, 4'h8);
    chk("t5_lsb_first", data_out_a, 4'h1);
    chk("t5_valid", data_valid_b, 1);
    idle();

    // 6: five Z words, CNT_W=2 saturates
    exp_a = 0;
    exp_b = 0;
    for (int k = 0; k < 5; k++) begin
      send(zb);
      send(1'b0);
      send(1'b0);
      send(1'b0);
      w4   = {1'b0, 1'b0, 1'b0, zb};
      exp4 = {zb, 1'b0, 1'b0, 1'b0};
      chk("t6_data_a", data_out_a, w4);
      chk("t6_data_b", data_out_b, exp4);
      chk("t6_xz_b", data_xz_b, zb_xz);
      idle();
      if (zb_xz) begin
        exp_a = exp_a + 1;
        if (exp_b < 3) exp_b = exp_b + 1;
      end
      chk("t6_sat_b", xz_words_b, exp_b);
      chk("t6_cnt_a", xz_words_a, exp_a);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=done",
             n_chk);
    $fatal(1);
  end

endmodule
